// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result streaming bus of pipelined_ripple_adder.
// master produces operands and consumes results; slave is the adder itself.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int STAGES = WIDTH / CHUNK;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_cin;
  logic              in_sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic              out_cout;
  logic              out_ovf;
  logic [STAGES-1:0] out_carries;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_carries
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_carries
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, carries and
// remaining operand bits registered between stages, valid/ready with full backpressure.
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_ripple_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  // Returns {carry out, chunk sum} of a CHUNK-bit full-adder ripple.
  function automatic logic [CHUNK:0] ripple_chunk(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             cin
  );
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    c    = {(CHUNK+1){1'b0}};
    s    = {CHUNK{1'b0}};
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[CHUNK], s};
  endfunction

  logic             stall_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  // Backpressure and subtract preprocessing at the accept point
  always_comb begin
    stall_s = bus.out_valid & ~bus.out_ready;
    if (bus.in_sub) begin
      b_eff_s = ~bus.in_b;
      c0_s    = ~bus.in_cin;
    end else begin
      b_eff_s = bus.in_b;
      c0_s    = bus.in_cin;
    end
  end

  assign bus.in_ready = ~stall_s;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * CHUNK;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]      a_in_s;
      logic [REM-1:0]      b_in_s;
      logic                c_in_s;
      logic                v_in_s;
      logic [CHUNK:0]      res_s;
      logic [LO+CHUNK-1:0] sum_nx_s;
      logic [k:0]          carries_nx_s;
      logic                v_r;
      logic [LO+CHUNK-1:0] sum_r;
      logic [k:0]          carries_r;

      assign res_s = ripple_chunk(a_in_s[CHUNK-1:0], b_in_s[CHUNK-1:0], c_in_s);

      if (k == 0) begin : g_src
        assign a_in_s       = bus.in_a;
        assign b_in_s       = b_eff_s;
        assign c_in_s       = c0_s;
        assign v_in_s       = bus.in_valid;
        assign sum_nx_s     = res_s[CHUNK-1:0];
        assign carries_nx_s = res_s[CHUNK];
      end else begin : g_src
        assign a_in_s       = g_stage[k-1].g_hold.a_r;
        assign b_in_s       = g_stage[k-1].g_hold.b_r;
        assign c_in_s       = g_stage[k-1].carries_r[k-1];
        assign v_in_s       = g_stage[k-1].v_r;
        assign sum_nx_s     = {res_s[CHUNK-1:0], g_stage[k-1].sum_r};
        assign carries_nx_s = {res_s[CHUNK], g_stage[k-1].carries_r};
      end

      // Stage valid, accumulated sum and carry chain; bubbles shift like data
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r       <= 1'b0;
          sum_r     <= {(LO+CHUNK){1'b0}};
          carries_r <= {(k+1){1'b0}};
        end else if (!stall_s) begin
          v_r       <= v_in_s;
          sum_r     <= sum_nx_s;
          carries_r <= carries_nx_s;
        end
      end

      if (k < STAGES - 1) begin : g_hold
        logic [REM-CHUNK-1:0] a_r;
        logic [REM-CHUNK-1:0] b_r;

        // Operand bits still waiting for later stages
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_r <= {(REM-CHUNK){1'b0}};
            b_r <= {(REM-CHUNK){1'b0}};
          end else if (!stall_s) begin
            a_r <= a_in_s[REM-1:CHUNK];
            b_r <= b_in_s[REM-1:CHUNK];
          end
        end
      end else begin : g_last
        logic ovf_r;

        // Carry into the MSB equals a^b^sum at that bit; overflow is it XOR carry out
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_r <= 1'b0;
          end else if (!stall_s) begin
            ovf_r <= a_in_s[CHUNK-1] ^ b_in_s[CHUNK-1] ^ res_s[CHUNK-1] ^ res_s[CHUNK];
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid   = g_stage[STAGES-1].v_r;
  assign bus.out_sum     = g_stage[STAGES-1].sum_r;
  assign bus.out_carries = g_stage[STAGES-1].carries_r;
  assign bus.out_cout    = g_stage[STAGES-1].carries_r[STAGES-1];
  assign bus.out_ovf     = g_stage[STAGES-1].g_last.ovf_r;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: directed table, stall/reset sequences and random traffic
// on three configurations (16/4, 32/8, 8/8) against an arithmetic reference model.
module tb_pipelined_ripple_adder;
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [7:0]  carries;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          cin;
    bit          sub;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int wd[3] = '{16, 32, 8};
  int ck[3] = '{4, 8, 8};

  logic        vin_v[3];
  logic        cin_v[3];
  logic        sub_v[3];
  logic        ordy_v[3];
  logic [63:0] a_v[3];
  logic [63:0] b_v[3];
  wire         rdy_v[3];
  wire         ov_v[3];
  wire         cout_v[3];
  wire         ovf_v[3];
  wire [63:0]  sum_v[3];
  wire [7:0]   car_v[3];

  pipelined_ripple_adder_if #(.WIDTH(16), .CHUNK(4)) if0 ();
  pipelined_ripple_adder_if #(.WIDTH(32), .CHUNK(8)) if1 ();
  pipelined_ripple_adder_if #(.WIDTH(8),  .CHUNK(8)) if2 ();

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pipelined_ripple_adder #(.WIDTH(32), .CHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipelined_ripple_adder #(.WIDTH(8),  .CHUNK(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.in_valid = vin_v[0];  assign if0.in_a = a_v[0][15:0]; assign if0.in_b = b_v[0][15:0];
  assign if0.in_cin = cin_v[0];    assign if0.in_sub = sub_v[0];   assign if0.out_ready = ordy_v[0];
  assign rdy_v[0] = if0.in_ready;  assign ov_v[0] = if0.out_valid; assign cout_v[0] = if0.out_cout;
  assign ovf_v[0] = if0.out_ovf;   assign sum_v[0] = {48'd0, if0.out_sum}; assign car_v[0] = {4'd0, if0.out_carries};

  assign if1.in_valid = vin_v[1];  assign if1.in_a = a_v[1][31:0]; assign if1.in_b = b_v[1][31:0];
  assign if1.in_cin = cin_v[1];    assign if1.in_sub = sub_v[1];   assign if1.out_ready = ordy_v[1];
  assign rdy_v[1] = if1.in_ready;  assign ov_v[1] = if1.out_valid; assign cout_v[1] = if1.out_cout;
  assign ovf_v[1] = if1.out_ovf;   assign sum_v[1] = {32'd0, if1.out_sum}; assign car_v[1] = {4'd0, if1.out_carries};

  assign if2.in_valid = vin_v[2];  assign if2.in_a = a_v[2][7:0];  assign if2.in_b = b_v[2][7:0];
  assign if2.in_cin = cin_v[2];    assign if2.in_sub = sub_v[2];   assign if2.out_ready = ordy_v[2];
  assign rdy_v[2] = if2.in_ready;  assign ov_v[2] = if2.out_valid; assign cout_v[2] = if2.out_cout;
  assign ovf_v[2] = if2.out_ovf;   assign sum_v[2] = {56'd0, if2.out_sum}; assign car_v[2] = {7'd0, if2.out_carries};

  int          errs = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  bit          prev_stall[3];
  logic [63:0] prev_sum[3];
  vec_t        tab[8];

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain integer arithmetic of A +/- B +/- cin, per-chunk carries from partial sums.
  function automatic exp_t model(input int w, input int c, input logic [63:0] a,
                                 input logic [63:0] b, input bit cin, input bit sub);
    exp_t   e;
    longint av, bv, t, mk, lim, sa, sb, r;
    av = longint'(a);
    bv = longint'(b);
    e  = '0;
    for (int k = 0; k < w / c; k++) begin
      mk = longint'(1) << ((k + 1) * c);
      if (sub) t = (av % mk) - (bv % mk) - longint'(cin);
      else     t = (av % mk) + (bv % mk) + longint'(cin);
      e.carries[k] = sub ? (t >= 0) : (t >= mk);
    end
    mk = longint'(1) << w;
    t  = sub ? av - bv - longint'(cin) : av + bv + longint'(cin);
    e.sum  = 64'(t) & (64'(mk) - 64'd1);
    e.cout = sub ? (t >= 0) : (t >= mk);
    lim = longint'(1) << (w - 1);
    sa  = (av >= lim) ? av - mk : av;
    sb  = (bv >= lim) ? bv - mk : bv;
    r   = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    e.ovf = (r < -lim) || (r >= lim);
    return e;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = msk(w);
      2:       r = 64'd1 << (w - 1);
      default: r = {$urandom, $urandom};
    endcase
    return r & msk(w);
  endfunction

  function automatic vec_t mkv(input logic [63:0] a, input logic [63:0] b, input bit cin, input bit sub,
                               input logic [63:0] s, input bit co, input bit ov, input logic [7:0] car);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.e.sum = s; v.e.cout = co; v.e.ovf = ov; v.e.carries = car;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1 unit later, score accept/emit for the coming posedge.
  task automatic step(input int idx, input bit vin, input logic [63:0] a, input logic [63:0] b,
                      input bit cin, input bit sub, input bit ordy, input bit use_tab,
                      input exp_t tab_e, output bit acc, output bit emit);
    exp_t e;
    @(negedge clk);
    vin_v[idx] = vin; a_v[idx] = a; b_v[idx] = b;
    cin_v[idx] = cin; sub_v[idx] = sub; ordy_v[idx] = ordy;
    #1;
    chk("in_ready", idx, rdy_v[idx], !(ov_v[idx] && !ordy));
    if (prev_stall[idx]) begin
      chk("stall_hold_valid", idx, ov_v[idx], 64'd1);
      chk("stall_hold_sum", idx, sum_v[idx], prev_sum[idx]);
    end
    prev_stall[idx] = ov_v[idx] && !ordy;
    prev_sum[idx]   = sum_v[idx];
    acc  = vin && rdy_v[idx];
    emit = ov_v[idx] && ordy;
    if (acc) exp_q.push_back(use_tab ? tab_e : model(wd[idx], ck[idx], a & msk(wd[idx]), b & msk(wd[idx]), cin, sub));
    if (emit) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_output[dut%0d]: got sum 0x%0h, expected no result", idx, sum_v[idx]);
      end else begin
        e = exp_q.pop_front();
        chk("sum", idx, sum_v[idx], e.sum);
        chk("cout", idx, cout_v[idx], e.cout);
        chk("ovf", idx, ovf_v[idx], e.ovf);
        chk("carries", idx, car_v[idx], e.carries);
      end
    end
  endtask

  // Sends one transaction and measures cycles until its result is taken.
  task automatic one_shot(input int idx, input vec_t v, input bit use_tab);
    bit acc, emit, got;
    int lat;
    step(idx, 1'b1, v.a, v.b, v.cin, v.sub, 1'b1, use_tab, v.e, acc, emit);
    chk("accept", idx, acc, 64'd1);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      step(idx, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, emit);
      if (emit) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("latency", idx, lat, wd[idx] / ck[idx]);
  endtask

  task automatic run_random(input int idx, input int n);
    logic [63:0] a, b;
    bit cin, sub, vin, ordy, acc, emit, pend;
    pend = 1'b0;
    a = 64'd0; b = 64'd0; cin = 1'b0; sub = 1'b0; vin = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!pend) begin
        a   = rnd_op(wd[idx]);
        b   = rnd_op(wd[idx]);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        vin = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(idx, vin, a, b, cin, sub, ordy, 1'b0, '0, acc, emit);
      pend = vin && !acc;
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++)
      step(idx, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, emit);
    chk("drain_empty", idx, exp_q.size(), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc, emit, saw_low, ordy;
    int   sent, nemit, first_rel, last_rel, n_rel;
    vec_t v;

    for (int i = 0; i < 3; i++) begin
      vin_v[i] = 1'b0; cin_v[i] = 1'b0; sub_v[i] = 1'b0; ordy_v[i] = 1'b1;
      a_v[i] = 64'd0;  b_v[i] = 64'd0;  prev_stall[i] = 1'b0; prev_sum[i] = 64'd0;
    end
    tab[0] = mkv(64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 8'hF);
    tab[1] = mkv(64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1, 8'h7);
    tab[2] = mkv(64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 8'h8);
    tab[3] = mkv(64'h0000, 64'h0001, 1'b0, 1'b1, 64'hFFFF, 1'b0, 1'b0, 8'h0);
    tab[4] = mkv(64'h1234, 64'h4321, 1'b1, 1'b0, 64'h5556, 1'b0, 1'b0, 8'h0);
    tab[5] = mkv(64'h0005, 64'h0003, 1'b1, 1'b1, 64'h0001, 1'b1, 1'b0, 8'hF);
    tab[6] = mkv(64'h8000, 64'h8000, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b1, 8'h8);
    tab[7] = mkv(64'hFFFF, 64'hFFFF, 1'b0, 1'b1, 64'h0000, 1'b1, 1'b0, 8'hF);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, ov_v[i], 64'd0);
      chk("rst_out_sum", i, sum_v[i], 64'd0);
      chk("rst_out_cout", i, cout_v[i], 64'd0);
      chk("rst_out_ovf", i, ovf_v[i], 64'd0);
      chk("rst_out_carries", i, car_v[i], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("in_ready_after_reset", i, rdy_v[i], 64'd1);

    // Directed vectors on the 16/4 configuration
    for (int i = 0; i < 8; i++) one_shot(0, tab[i], 1'b1);

    // Back-to-back stream with a stall window
    sent = 0; nemit = 0; first_rel = -1; last_rel = -1; n_rel = 0; saw_low = 1'b0;
    for (int c = 0; c < 60 && nemit < 8; c++) begin
      ordy = !(c >= 5 && c <= 10);
      step(0, sent < 8, 64'(sent), 64'h1000 * 64'(sent), 1'b0, 1'b0, ordy, 1'b0, '0, acc, emit);
      if (acc) sent++;
      if (!rdy_v[0]) saw_low = 1'b1;
      if (emit) begin
        nemit++;
        if (c > 10) begin
          if (first_rel < 0) first_rel = c;
          last_rel = c;
          n_rel++;
        end
      end
    end
    chk("stream_emitted", 0, nemit, 64'd8);
    chk("stream_in_ready_dropped", 0, saw_low, 64'd1);
    chk("stream_rate_after_release", 0, n_rel, last_rel - first_rel + 1);
    chk("stream_queue_empty", 0, exp_q.size(), 64'd0);

    // Reset pulse with transactions in flight
    for (int i = 0; i < 4; i++)
      step(0, 1'b1, 64'h0100 + 64'(i), 64'h0011, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, emit);
    @(negedge clk);
    vin_v[0] = 1'b0;
    #1;
    chk("valid_before_reset", 0, ov_v[0], 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 0, ov_v[0], 64'd0);
    chk("midrst_out_sum", 0, sum_v[0], 64'd0);
    chk("midrst_out_cout", 0, cout_v[0], 64'd0);
    chk("midrst_out_ovf", 0, ovf_v[0], 64'd0);
    chk("midrst_out_carries", 0, car_v[0], 64'd0);
    #4;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    for (int c = 0; c < 8; c++)
      step(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, emit);
    v = mkv(64'h1234, 64'h0FCD, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 8'h0);
    one_shot(0, v, 1'b0);

    // Single-stage and wide configurations
    v = mkv(64'hFF, 64'h01, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 8'h0);
    one_shot(2, v, 1'b0);
    v = mkv(64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 8'h0);
    one_shot(1, v, 1'b0);

    run_random(0, 300);
    run_random(1, 300);
    run_random(2, 300);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
